// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl
// Operand-preparation and result-collection stage in front of the 33-bit
// iterative multiplier (basemul). It accepts MUL/MULH/MULHSU/MULHU requests
// and sign- or zero-extends the operands to 33 bits. It issues them over a
// valid/ready handshake and catches the multiplier's one-cycle result pulse.
// The selected 32-bit half is then returned under a valid/ready response
// handshake. Optionally, a zero operand bypasses the multiplier entirely.
//
// Ports
//   clk, resetn                       clock, asynchronous active-low reset
//   req_valid/req_ready               request handshake
//   req_op, req_a, req_b, req_tag     operation, operands, opaque tag
//   mul_src1, mul_src2                33-bit extended operands to multiplier
//   mul_in_valid/mul_in_ready         multiplier input handshake
//   mul_out_valid, mul_result         multiplier result pulse and product
//   resp_valid/resp_ready             response handshake
//   resp_data, resp_tag               selected result half and its tag

module mul_issue_ctrl #(
    parameter int unsigned TAG_W       = 4,
    parameter bit          ZERO_BYPASS = 1'b1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [TAG_W-1:0] req_tag,
    output logic [32:0]      mul_src1,
    output logic [32:0]      mul_src2,
    output logic             mul_in_valid,
    input  logic             mul_in_ready,
    input  logic             mul_out_valid,
    input  logic [63:0]      mul_result,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b11;

    state_t            state_q;
    logic [1:0]        op_q;
    logic [32:0]       src1_q, src2_q;
    logic              in_valid_q, resp_valid_q;
    logic [31:0]       resp_data_q;
    logic [TAG_W-1:0]  resp_tag_q;

    logic [32:0]       src1_d, src2_d;
    logic              bypass_d;

    // rs1 is signed for everything except MULHU; rs2 is signed only for
    // MUL/MULH (op[1] clear). The extra top bit lets the signed 33x33
    // multiplier cover all four variants.
    assign src1_d   = {(req_op != OP_MULHU) & req_a[31], req_a};
    assign src2_d   = {~req_op[1] & req_b[31], req_b};
    assign bypass_d = ZERO_BYPASS && ((req_a == 32'd0) || (req_b == 32'd0));

    // Decoded from registered state, so it never depends on req_valid.
    assign req_ready = (state_q == S_IDLE);

    // NOTE: every register below is assigned with <=, so all of them sample
    // the values from before the edge regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            op_q         <= 2'b00;
            src1_q       <= '0;
            src2_q       <= '0;
            in_valid_q   <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_tag_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q       <= req_op;
                        resp_tag_q <= req_tag;
                        src1_q     <= src1_d;
                        src2_q     <= src2_d;
                        if (bypass_d) begin
                            resp_data_q  <= '0;
                            resp_valid_q <= 1'b1;
                            state_q      <= S_RESP;
                        end else begin
                            in_valid_q <= 1'b1;
                            state_q    <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // Operands stay put until the multiplier takes them.
                    if (mul_in_ready) begin
                        in_valid_q <= 1'b0;
                        state_q    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mul_out_valid) begin
                        resp_data_q  <= (op_q == OP_MUL) ? mul_result[31:0]
                                                         : mul_result[63:32];
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Result pulses outside WAIT are deliberately ignored.
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mul_src1     = src1_q;
    assign mul_src2     = src2_q;
    assign mul_in_valid = in_valid_q;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_tag     = resp_tag_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_tag = '0;
    logic [32:0] mul_src1, mul_src2;
    logic        mul_in_valid;
    logic        mul_in_ready = 1'b0;
    logic        mul_out_valid = 1'b0;
    logic [63:0] mul_result = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [3:0]  resp_tag;

    int checks = 0;
    int errors = 0;

    mul_issue_ctrl #(.TAG_W(4), .ZERO_BYPASS(1'b1)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .mul_src1(mul_src1), .mul_src2(mul_src2),
        .mul_in_valid(mul_in_valid), .mul_in_ready(mul_in_ready),
        .mul_out_valid(mul_out_valid), .mul_result(mul_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_tag(resp_tag)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic send_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] tag);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_before_send got=%b exp=1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag;
        @(negedge clk);
        req_valid = 1'b0; req_a = '0; req_b = '0; req_tag = '0;
    endtask

    // Acts as the multiplier for one operation and drains the response.
    task automatic run_mul(input string name, input logic [32:0] e_src1, input logic [32:0] e_src2,
                           input logic [63:0] result, input logic [31:0] e_data,
                           input logic [3:0] e_tag, input int ready_delay, input int resp_stall);
        int n = 0;
        while (mul_in_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (mul_in_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s issue_timeout mul_in_valid=%b exp=1", name, mul_in_valid);
            return;
        end
        for (int i = 0; i <= ready_delay; i++) begin
            checks += 4;
            if (mul_src1 !== e_src1) begin
                errors++; $display("FAIL %s src1 cyc%0d got=%h exp=%h", name, i, mul_src1, e_src1);
            end
            if (mul_src2 !== e_src2) begin
                errors++; $display("FAIL %s src2 cyc%0d got=%h exp=%h", name, i, mul_src2, e_src2);
            end
            if (mul_in_valid !== 1'b1) begin
                errors++; $display("FAIL %s in_valid_hold cyc%0d got=%b exp=1", name, i, mul_in_valid);
            end
            if (req_ready !== 1'b0) begin
                errors++; $display("FAIL %s req_ready_issue cyc%0d got=%b exp=0", name, i, req_ready);
            end
            if (i == ready_delay) mul_in_ready = 1'b1;
            @(negedge clk);
        end
        mul_in_ready = 1'b0;
        checks++;
        if (mul_in_valid !== 1'b0) begin
            errors++; $display("FAIL %s in_valid_drop got=%b exp=0", name, mul_in_valid);
        end
        repeat (3) @(negedge clk);
        mul_out_valid = 1'b1; mul_result = result;
        @(negedge clk);
        mul_out_valid = 1'b0; mul_result = '0;
        for (int i = 0; i <= resp_stall; i++) begin
            checks += 4;
            if (resp_valid !== 1'b1) begin
                errors++; $display("FAIL %s resp_valid cyc%0d got=%b exp=1", name, i, resp_valid);
            end
            if (resp_data !== e_data) begin
                errors++; $display("FAIL %s resp_data cyc%0d got=%h exp=%h", name, i, resp_data, e_data);
            end
            if (resp_tag !== e_tag) begin
                errors++; $display("FAIL %s resp_tag cyc%0d got=%h exp=%h", name, i, resp_tag, e_tag);
            end
            if (req_ready !== 1'b0) begin
                errors++; $display("FAIL %s req_ready_resp cyc%0d got=%b exp=0", name, i, req_ready);
            end
            if (i == resp_stall) begin
                resp_ready = 1'b1;
            end else if (i == 0) begin
                // Stray result pulse while holding a response.
                mul_out_valid = 1'b1; mul_result = ~result;
            end
            @(negedge clk);
            mul_out_valid = 1'b0; mul_result = '0;
        end
        resp_ready = 1'b0;
        checks += 2;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL %s resp_valid_drop got=%b exp=0", name, resp_valid);
        end
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL %s req_ready_return got=%b exp=1", name, req_ready);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks += 5;
        if (mul_in_valid !== 1'b0) begin errors++; $display("FAIL rst_in_valid got=%b exp=0", mul_in_valid); end
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        if (resp_data !== 32'd0) begin errors++; $display("FAIL rst_resp_data got=%h exp=0", resp_data); end
        if (resp_tag !== 4'd0) begin errors++; $display("FAIL rst_resp_tag got=%h exp=0", resp_tag); end
        if ({mul_src1, mul_src2} !== 66'd0) begin
            errors++; $display("FAIL rst_src got=%h/%h exp=0", mul_src1, mul_src2);
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_ops();
        send_req(2'b00, 32'd7, 32'd6, 4'h3);
        run_mul("mul", 33'h0_00000007, 33'h0_00000006, 64'h0000_0000_0000_002A, 32'h0000002A, 4'h3, 0, 0);
        send_req(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h5);
        run_mul("mulh", 33'h1_FFFFFFFF, 33'h1_FFFFFFFF, 64'h0000_0000_0000_0001, 32'h00000000, 4'h5, 0, 0);
        send_req(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h9);
        run_mul("mulhu", 33'h0_FFFFFFFF, 33'h0_FFFFFFFF, 64'hFFFF_FFFE_0000_0001, 32'hFFFFFFFE, 4'h9, 0, 0);
        send_req(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'hA);
        run_mul("mulhsu", 33'h1_FFFFFFFF, 33'h0_FFFFFFFF, 64'hFFFF_FFFF_0000_0001, 32'hFFFFFFFF, 4'hA, 0, 0);
    endtask

    task automatic test_zero_bypass();
        send_req(2'b00, 32'd0, 32'h1234, 4'hC);
        checks += 4;
        if (mul_in_valid !== 1'b0) begin errors++; $display("FAIL byp_in_valid got=%b exp=0", mul_in_valid); end
        if (resp_valid !== 1'b1) begin errors++; $display("FAIL byp_resp_valid got=%b exp=1", resp_valid); end
        if (resp_data !== 32'd0) begin errors++; $display("FAIL byp_resp_data got=%h exp=0", resp_data); end
        if (resp_tag !== 4'hC) begin errors++; $display("FAIL byp_resp_tag got=%h exp=c", resp_tag); end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks += 3;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL byp_resp_drop got=%b exp=0", resp_valid); end
        if (mul_in_valid !== 1'b0) begin errors++; $display("FAIL byp_in_valid_after got=%b exp=0", mul_in_valid); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL byp_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_backpressure();
        // -3 * 0x10 = -48: low half 0xFFFFFFD0
        send_req(2'b00, 32'hFFFFFFFD, 32'h00000010, 4'h6);
        run_mul("stall", 33'h1_FFFFFFFD, 33'h0_00000010, 64'hFFFF_FFFF_FFFF_FFD0, 32'hFFFFFFD0, 4'h6, 5, 10);
    endtask

    task automatic test_reset_mid_op();
        int n = 0;
        send_req(2'b01, 32'd3, 32'd5, 4'h7);
        while (mul_in_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        mul_in_ready = 1'b1;
        @(negedge clk);
        mul_in_ready = 1'b0;
        #2 resetn = 1'b0;
        #1;
        checks += 5;
        if (mul_in_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_in_valid got=%b exp=0", mul_in_valid); end
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_resp_valid got=%b exp=0", resp_valid); end
        if (resp_tag !== 4'd0) begin errors++; $display("FAIL mid_rst_resp_tag got=%h exp=0", resp_tag); end
        if ({mul_src1, mul_src2} !== 66'd0) begin
            errors++; $display("FAIL mid_rst_src got=%h/%h exp=0", mul_src1, mul_src2);
        end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_idle got=%b exp=1", req_ready); end
        @(negedge clk);
        resetn = 1'b1;
        // Stale result after reset, with resp_ready held high while idle.
        mul_out_valid = 1'b1; mul_result = 64'd15; resp_ready = 1'b1;
        @(negedge clk);
        mul_out_valid = 1'b0; mul_result = '0;
        @(negedge clk);
        resp_ready = 1'b0;
        checks += 3;
        if (resp_valid !== 1'b0) begin errors++; $display("FAIL stale_resp_valid got=%b exp=0", resp_valid); end
        if (mul_in_valid !== 1'b0) begin errors++; $display("FAIL stale_in_valid got=%b exp=0", mul_in_valid); end
        if (req_ready !== 1'b1) begin errors++; $display("FAIL stale_req_ready got=%b exp=1", req_ready); end
        send_req(2'b00, 32'd3, 32'd5, 4'hE);
        run_mul("after_rst", 33'h0_00000003, 33'h0_00000005, 64'd15, 32'd15, 4'hE, 1, 1);
    endtask

    initial begin
        test_reset();
        test_ops();
        test_zero_bypass();
        test_backpressure();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
